// File: rtl/photo_pkg.sv
// Shared definitions for the photo load scheduler.
// Holds the scheduler state encoding, the default image geometry and the
// sector-count constants derived from it. Default geometry is a 640x480
// background followed by 46 sprites of 24320 pixels, stored as RGB565, so
// 256 pixels fill one 512-byte SD sector.
package photo_pkg;

  localparam int          BG_PIX_DEF    = 307200;
  localparam int          PIC_PIX_DEF   = 24320;
  localparam int          PHOTO_NUM_DEF = 46;
  localparam int          SEC_PIX_DEF   = 256;
  localparam logic [31:0] BASE_SEC_DEF  = 32'd16640;

  localparam int BG_SEC_DEF  = BG_PIX_DEF / SEC_PIX_DEF;   // 1200
  localparam int PIC_SEC_DEF = PIC_PIX_DEF / SEC_PIX_DEF;  // 95

  localparam logic [1:0]  RETRY_MAX  = 2'd3;
  localparam logic [1:0]  SETTLE_LD  = 2'd3;    // down-count 3..0 = 4 cycles
  localparam logic [15:0] WD_LIMIT   = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_NEXT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/photo_load_sched_if.sv
// SD-controller read handshake between the scheduler and the SD controller.
//   rd_start_en  one-cycle sector-read request (scheduler -> SD)
//   rd_sec_addr  sector address, held until rd_busy falls (scheduler -> SD)
//   rd_busy      SD read in progress (SD -> scheduler)
//   wr_en        one pulse per received 16-bit pixel (SD -> scheduler)
interface photo_load_sched_if;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        rd_busy;
  logic        wr_en;

  modport master (output rd_start_en, output rd_sec_addr,
                  input  rd_busy,     input  wr_en);
  modport slave  (input  rd_start_en, input  rd_sec_addr,
                  output rd_busy,     output wr_en);
endinterface

// File: rtl/photo_win_calc.sv
// SDRAM write-window and SD sector-base generator.
// On each load strobe it steps to the next image: image 0 gets [0, BG_PIX),
// every sprite gets the PIC_PIX-wide window following the previous one.
// The sector base is a running sum of previous images' sector counts, so no
// multiplier is needed.
// Ports: clk, rst (async, active high), load (advance strobe), first (the
// image being loaded is the background), win_min_addr/win_max_addr (window,
// max exclusive), sec_base (sector offset of the image being loaded).
module photo_win_calc
  import photo_pkg::*;
#(
  parameter int BG_PIX  = BG_PIX_DEF,
  parameter int PIC_PIX = PIC_PIX_DEF,
  parameter int BG_SEC  = BG_SEC_DEF,
  parameter int PIC_SEC = PIC_SEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        first,
  output logic [20:0] win_min_addr,
  output logic [20:0] win_max_addr,
  output logic [31:0] sec_base
);

  logic [20:0] min_q, min_d, max_q, max_d;
  logic [31:0] base_q, base_d, next_q, next_d;

  always_comb begin
    min_d  = min_q;
    max_d  = max_q;
    base_d = base_q;
    next_d = next_q;
    if (load) begin
      if (first) begin
        min_d  = '0;
        max_d  = 21'(BG_PIX);
        base_d = '0;
        next_d = 32'(BG_SEC);
      end else begin
        min_d  = max_q;
        max_d  = max_q + 21'(PIC_PIX);
        base_d = next_q;
        next_d = next_q + 32'(PIC_SEC);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q  <= '0;
      max_q  <= 21'(BG_PIX);
      base_q <= '0;
      next_q <= '0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      base_q <= base_d;
      next_q <= next_d;
    end
  end

  assign win_min_addr = min_q;
  assign win_max_addr = max_q;
  assign sec_base     = base_q;

endmodule

// File: rtl/photo_load_sched.sv
// Photo load scheduler: streams the background and all sprites from SD card
// into SDRAM one sector at a time, re-reading short sectors a few times.
// Optional feature: define PHOTO_SCHED_TIMEOUT_EN to add a 16-bit watchdog
// on the read handshake and the sticky timeout_err output.
// Ports: clk, rst (async, active high), start (one-cycle go), sd (SD read
// handshake, master side), win_min_addr/win_max_addr (SDRAM write window),
// wr_load (SDRAM write-port reset pulse), photo_load_cnt (image index),
// busy, done, timeout_err (only with PHOTO_SCHED_TIMEOUT_EN).
module photo_load_sched
  import photo_pkg::*;
#(
  parameter int          BG_PIX    = BG_PIX_DEF,
  parameter int          PIC_PIX   = PIC_PIX_DEF,
  parameter int          PHOTO_NUM = PHOTO_NUM_DEF,
  parameter logic [31:0] BASE_SEC  = BASE_SEC_DEF,
  parameter int          SEC_PIX   = SEC_PIX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  photo_load_sched_if.master  sd,
  output logic [20:0]         win_min_addr,
  output logic [20:0]         win_max_addr,
  output logic                wr_load,
  output logic [7:0]          photo_load_cnt,
  output logic                busy,
  output logic                done
`ifdef PHOTO_SCHED_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  localparam int         BG_SEC   = BG_PIX / SEC_PIX;
  localparam int         PIC_SEC  = PIC_PIX / SEC_PIX;
  localparam logic [8:0] PIX_FULL = 9'(SEC_PIX);

  state_e      state_q, state_d;
  logic [7:0]  img_q, img_d;
  logic [15:0] sec_q, sec_d;
  logic [1:0]  retry_q, retry_d;
  logic [1:0]  settle_q, settle_d;
  logic [8:0]  pix_q, pix_d;
  logic [31:0] addr_q, addr_d;
  logic        hi_q, hi_d;
  logic        adv;
  logic [15:0] sec_last;
  logic [31:0] sec_base;
`ifdef PHOTO_SCHED_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  photo_win_calc #(
    .BG_PIX  (BG_PIX),
    .PIC_PIX (PIC_PIX),
    .BG_SEC  (BG_SEC),
    .PIC_SEC (PIC_SEC)
  ) u_win (
    .clk          (clk),
    .rst          (rst),
    .load         (state_q == ST_LOAD),
    .first        (img_q == 8'd0),
    .win_min_addr (win_min_addr),
    .win_max_addr (win_max_addr),
    .sec_base     (sec_base)
  );

  assign sec_last = (img_q == 8'd0) ? 16'(BG_SEC - 1) : 16'(PIC_SEC - 1);

  always_comb begin
    state_d  = state_q;
    img_d    = img_q;
    sec_d    = sec_q;
    retry_d  = retry_q;
    settle_d = settle_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    adv      = 1'b0;
    pix_d    = pix_q;
    if (state_q == ST_ISSUE)
      pix_d = '0;
    else if (sd.wr_en && pix_q != 9'h1FF)
      pix_d = pix_q + 9'd1;
`ifdef PHOTO_SCHED_TIMEOUT_EN
    err_d = err_q;
    wd_d  = '0;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          img_d   = '0;
          sec_d   = '0;
          retry_d = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        settle_d = SETTLE_LD;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == 2'd0) state_d = ST_ISSUE;
        else                  settle_d = settle_q - 2'd1;
      end
      ST_ISSUE: begin
        // rd_busy already up here counts as the rising edge having been seen
        hi_d    = sd.rd_busy;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: if (sd.rd_busy || hi_q) state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (!sd.rd_busy) state_d = ST_NEXT;
      ST_NEXT: begin
        if (pix_q == PIX_FULL || retry_q == RETRY_MAX) begin
          adv = 1'b1;
        end else begin
          retry_d = retry_q + 2'd1;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PHOTO_SCHED_TIMEOUT_EN
    if (state_q == ST_WAIT_HI || state_q == ST_WAIT_LO) begin
      if (wd_q == WD_LIMIT) begin
        if (retry_q == RETRY_MAX) begin
          err_d = 1'b1;
          adv   = 1'b1;
        end else begin
          retry_d = retry_q + 2'd1;
          state_d = ST_ISSUE;
        end
      end else begin
        wd_d = wd_q + 16'd1;
      end
    end
`endif

    if (adv) begin
      retry_d = '0;
      if (sec_q == sec_last) begin
        sec_d   = '0;
        img_d   = img_q + 8'd1;
        state_d = (img_q == 8'(PHOTO_NUM)) ? ST_DONE : ST_LOAD;
      end else begin
        sec_d   = sec_q + 16'd1;
        state_d = ST_ISSUE;
      end
    end

    // latch the address on entry to ISSUE so it stays put through the read
    if (state_d == ST_ISSUE && state_q != ST_ISSUE)
      addr_d = BASE_SEC + sec_base + {16'd0, sec_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      img_q    <= '0;
      sec_q    <= '0;
      retry_q  <= '0;
      settle_q <= '0;
      pix_q    <= '0;
      addr_q   <= '0;
      hi_q     <= 1'b0;
`ifdef PHOTO_SCHED_TIMEOUT_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      img_q    <= img_d;
      sec_q    <= sec_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
      pix_q    <= pix_d;
      addr_q   <= addr_d;
      hi_q     <= hi_d;
`ifdef PHOTO_SCHED_TIMEOUT_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  assign sd.rd_start_en = (state_q == ST_ISSUE);
  assign sd.rd_sec_addr = addr_q;
  assign wr_load        = (state_q == ST_LOAD);
  assign photo_load_cnt = img_q;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done           = (state_q == ST_DONE);
`ifdef PHOTO_SCHED_TIMEOUT_EN
  assign timeout_err    = err_q;
`endif

endmodule

// File: doc/photo_load_sched.md
PHOTO_LOAD_SCHED -- requirements
Module: photo_load_sched

Interface
REQ-001 Parameter BG_PIX, default 307200, pixel count of background image 0.
REQ-002 Parameter PIC_PIX, default 24320, pixel count of each sprite image 1..PHOTO_NUM.
REQ-003 Parameter PHOTO_NUM, default 46, number of sprite images after the background.
REQ-004 Parameter BASE_SEC, default 32'd16640, SD sector of first image; images are stored back to back.
REQ-005 Parameter SEC_PIX, default 256, pixels per 512-byte sector (16-bit RGB565).
REQ-006 clk  in  1  single clock, 12.5 MHz SD-side domain.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 start  in  1  one-cycle pulse; begins loading the full image set.
REQ-009 rd_busy  in  1  SD controller read-busy.
REQ-010 wr_en  in  1  SD read-data-valid, one pulse per 16-bit pixel.
REQ-011 rd_start_en  out  1  one-cycle sector-read request to the SD controller.
REQ-012 rd_sec_addr  out  32  sector address, held valid while rd_start_en is high and until rd_busy falls.
REQ-013 win_min_addr  out  21  SDRAM write-window start.
REQ-014 win_max_addr  out  21  SDRAM write-window end, exclusive.
REQ-015 wr_load  out  1  one-cycle pulse; resets the SDRAM write port.
REQ-016 photo_load_cnt  out  8  index of the image being loaded; 0 is the background.
REQ-017 busy  out  1  high from acceptance of start until done.
REQ-018 done  out  1  sticky high after the last image completes; cleared by the next start.

Function
REQ-019 States: IDLE, LOAD, SETTLE, ISSUE, WAIT_HI, WAIT_LO, NEXT, DONE.
REQ-020 IDLE: start=1 -> LOAD; photo_load_cnt<=0, sec_cnt<=0, done<=0, busy<=1.
REQ-021 LOAD, 1 cycle: set the window, assert wr_load for exactly this cycle -> SETTLE.
REQ-022 Window for image 0: min=0, max=BG_PIX.
REQ-023 Window for image n>=1: min=BG_PIX+(n-1)*PIC_PIX, max=BG_PIX+n*PIC_PIX; computed in 21 bits without overflow at n=PHOTO_NUM (max 1,425,920).
REQ-024 Window outputs change only in the LOAD state.
REQ-025 SETTLE: holds 4 cycles so the SDRAM FIFO clear completes -> ISSUE.
REQ-026 ISSUE: rd_start_en=1 for 1 cycle with rd_sec_addr=BASE_SEC+img_sec_base+sec_cnt -> WAIT_HI.
REQ-027 Sectors per image: image 0 = BG_PIX/SEC_PIX (1200); sprites = PIC_PIX/SEC_PIX (95).
REQ-028 img_sec_base is the running sum of the sector counts of prior images, accumulated and not multiplied.
REQ-029 WAIT_HI: on rd_busy=1 -> WAIT_LO.
REQ-030 WAIT_LO: on rd_busy=0 -> NEXT.
REQ-031 NEXT: check the wr_en count for the sector; count==SEC_PIX -> sec_cnt+1.
REQ-032 NEXT, short sector (count!=SEC_PIX): re-issue the same sector, at most 3 retries, then advance anyway.
REQ-033 NEXT, last sector of an image: photo_load_cnt+1 -> LOAD.
REQ-034 NEXT, last sector of image PHOTO_NUM -> DONE.
REQ-035 DONE: busy=0, done=1, photo_load_cnt=PHOTO_NUM+1; start -> restart as in REQ-020.
REQ-036 start is ignored while busy=1.
REQ-037 rd_busy already high in ISSUE is treated as WAIT_HI satisfied on the next cycle.
REQ-038 The wr_en counter is 9 bits, cleared in ISSUE, and saturates at 511.

Reset
REQ-039 On rst=1, asynchronously: state=IDLE; all outputs 0 except win_max_addr=BG_PIX.
REQ-040 Reset mid-transfer abandons the load; no wr_load is issued until the next start.

Configuration
REQ-041 Macro PHOTO_SCHED_TIMEOUT_EN defined: a 16-bit watchdog runs in WAIT_HI and WAIT_LO.
REQ-042 Watchdog expiry at 65535 cycles: re-issue the sector and count the retry; retry overflow sets sticky output timeout_err.
REQ-043 Macro PHOTO_SCHED_TIMEOUT_EN undefined: no watchdog and no timeout_err port; WAIT states wait indefinitely.

Structure
REQ-044 Shared package photo_pkg holds the state enum, BG_PIX, PIC_PIX, PHOTO_NUM, SEC_PIX and the sector-count constants.
REQ-045 One sub-module, photo_win_calc: registered window and sector-base accumulator, advanced on the LOAD strobe.

Verification
REQ-046 Reset, then start, with the SD model returning 256 wr_en per sector -> rd_sec_addr runs 16640..17839 for image 0 with window 0/307200.
REQ-047 Image 1 -> wr_load pulse, window 307200/331520, first sector 17840.
REQ-048 Full run -> 46 sprites, last sector 17839+46*95=22209, done=1, photo_load_cnt=47.
REQ-049 Sector returning 200 wr_en -> same address re-issued up to 3 times, then advance.
REQ-050 start pulse during busy -> ignored; reset asserted in WAIT_LO -> all outputs at reset values within the same cycle.
REQ-051 With PHOTO_SCHED_TIMEOUT_EN defined and rd_busy stuck low -> re-issue after 65535 cycles; timeout_err=1 after 3 retries.
